// File: rtl/trap_sequencer_if.sv
// Bundle of commit-side, CSR-side and fetch-redirect signals of the machine-mode trap sequencer.
// The master drives the commit/CSR inputs; the slave is the sequencer itself.
interface trap_sequencer_if #(
    parameter int XLEN       = 32,
    parameter int CODE_WIDTH = 5
);
    logic                  exception_i;
    logic [CODE_WIDTH-1:0] exception_code_i;
    logic [XLEN-1:0]       exception_pc_i;
    logic                  commit_valid_i;
    logic [XLEN-1:0]       commit_pc_i;
    logic                  mret_i;
    logic                  mei_i;
    logic                  mti_i;
    logic                  msi_i;
    logic [XLEN-1:0]       mie_i;
    logic                  mstatus_mie_i;
    logic [1:0]            mstatus_mpp_i;
    logic [XLEN-1:0]       mtvec_i;
    logic [XLEN-1:0]       mepc_i;

    logic                  busy_o;
    logic                  flush_o;
    logic                  mepc_we_o;
    logic [XLEN-1:0]       mepc_o;
    logic                  mcause_we_o;
    logic [XLEN-1:0]       mcause_o;
    logic                  mstatus_trap_o;
    logic                  mstatus_mret_o;
    logic                  pc_load_o;
    logic [XLEN-1:0]       pc_target_o;
    logic [1:0]            priv_o;

    modport master (
        output exception_i, exception_code_i, exception_pc_i,
        output commit_valid_i, commit_pc_i, mret_i,
        output mei_i, mti_i, msi_i, mie_i,
        output mstatus_mie_i, mstatus_mpp_i, mtvec_i, mepc_i,
        input  busy_o, flush_o, mepc_we_o, mepc_o, mcause_we_o, mcause_o,
        input  mstatus_trap_o, mstatus_mret_o, pc_load_o, pc_target_o, priv_o
    );

    modport slave (
        input  exception_i, exception_code_i, exception_pc_i,
        input  commit_valid_i, commit_pc_i, mret_i,
        input  mei_i, mti_i, msi_i, mie_i,
        input  mstatus_mie_i, mstatus_mpp_i, mtvec_i, mepc_i,
        output busy_o, flush_o, mepc_we_o, mepc_o, mcause_we_o, mcause_o,
        output mstatus_trap_o, mstatus_mret_o, pc_load_o, pc_target_o, priv_o
    );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and MRET, sequences CSR side-effects.
// Optional feature macro TRAP_VECTORED_MODE_EN: mtvec MODE=01 sends interrupts to BASE+4*code.
module trap_sequencer #(
    parameter int XLEN       = 32,
    parameter int CODE_WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    trap_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SAVE = 2'b01,
        ST_JUMP = 2'b10,
        ST_RET  = 2'b11
    } state_e;

    localparam logic [1:0] PRIV_USER    = 2'b00;
    localparam logic [1:0] PRIV_MACHINE = 2'b11;

    localparam logic [CODE_WIDTH-1:0] CODE_MSI = CODE_WIDTH'(3);
    localparam logic [CODE_WIDTH-1:0] CODE_MTI = CODE_WIDTH'(7);
    localparam logic [CODE_WIDTH-1:0] CODE_MEI = CODE_WIDTH'(11);

    // mcause layout: interrupt flag in the MSB, code zero-extended in the low bits
    function automatic logic [XLEN-1:0] make_cause(input logic                  is_irq,
                                                   input logic [CODE_WIDTH-1:0] code);
        logic [XLEN-1:0] cause;
        cause                   = {XLEN{1'b0}};
        cause[CODE_WIDTH-1:0]   = code;
        cause[XLEN-1]           = is_irq;
        return cause;
    endfunction

    // Fixed interrupt priority MEI > MSI > MTI; pend = {mei, msi, mti} already masked by mie
    function automatic logic [CODE_WIDTH-1:0] irq_code(input logic [2:0] pend);
        logic [CODE_WIDTH-1:0] code;
        if (pend[2]) begin
            code = CODE_MEI;
        end else if (pend[1]) begin
            code = CODE_MSI;
        end else begin
            code = CODE_MTI;
        end
        return code;
    endfunction

    function automatic logic [XLEN-1:0] vector_base(input logic [XLEN-1:0] mtvec);
        return {mtvec[XLEN-1:2], 2'b00};
    endfunction

    state_e          state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [1:0]      mpp_q, mpp_d;
    logic [1:0]      priv_q, priv_d;

    logic            busy_q, busy_d;
    logic            flush_q, flush_d;
    logic            mepc_we_q, mepc_we_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic            mcause_we_q, mcause_we_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic            mtrap_q, mtrap_d;
    logic            mret_q, mret_d;
    logic            pc_load_q, pc_load_d;
    logic [XLEN-1:0] pc_target_q, pc_target_d;

    logic [2:0]            pend_s;
    logic                  irq_global_s;
    logic                  irq_take_s;
    logic [CODE_WIDTH-1:0] irq_code_s;
    logic [XLEN-1:0]       irq_target_s;
    logic [XLEN-1:0]       exc_cause_s;
    logic [XLEN-1:0]       irq_cause_s;
    logic                  unused_s;

    assign pend_s       = {bus.mei_i & bus.mie_i[11],
                           bus.msi_i & bus.mie_i[3],
                           bus.mti_i & bus.mie_i[7]};
    assign irq_global_s = bus.mstatus_mie_i | (priv_q == PRIV_USER);
    assign irq_take_s   = bus.commit_valid_i & irq_global_s & (pend_s != 3'b000);
    assign irq_code_s   = irq_code(pend_s);
    assign exc_cause_s  = make_cause(1'b0, bus.exception_code_i);
    assign irq_cause_s  = make_cause(1'b1, irq_code_s);

`ifdef TRAP_VECTORED_MODE_EN
    // Vectored mode only redirects interrupts; exceptions always land on BASE
    always_comb begin
        irq_target_s = vector_base(bus.mtvec_i);
        if (bus.mtvec_i[1:0] == 2'b01) begin
            irq_target_s = vector_base(bus.mtvec_i)
                         + {{(XLEN-CODE_WIDTH-2){1'b0}}, irq_code_s, 2'b00};
        end else begin
            irq_target_s = vector_base(bus.mtvec_i);
        end
    end
`else
    assign irq_target_s = vector_base(bus.mtvec_i);
`endif

    assign unused_s = ^{bus.mie_i, bus.mtvec_i[1:0]};

    // Next-state and registered-output values; inputs are only looked at in IDLE
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        tgt_d       = tgt_q;
        mpp_d       = mpp_q;
        priv_d      = priv_q;
        busy_d      = 1'b0;
        flush_d     = 1'b0;
        mepc_we_d   = 1'b0;
        mepc_d      = {XLEN{1'b0}};
        mcause_we_d = 1'b0;
        mcause_d    = {XLEN{1'b0}};
        mtrap_d     = 1'b0;
        mret_d      = 1'b0;
        pc_load_d   = 1'b0;
        pc_target_d = {XLEN{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (bus.exception_i) begin
                    state_d     = ST_SAVE;
                    cause_d     = exc_cause_s;
                    epc_d       = bus.exception_pc_i;
                    tgt_d       = vector_base(bus.mtvec_i);
                    busy_d      = 1'b1;
                    flush_d     = 1'b1;
                    mepc_we_d   = 1'b1;
                    mepc_d      = bus.exception_pc_i & ~{{(XLEN-1){1'b0}}, 1'b1};
                    mcause_we_d = 1'b1;
                    mcause_d    = exc_cause_s;
                    mtrap_d     = 1'b1;
                end else if (irq_take_s) begin
                    state_d     = ST_SAVE;
                    cause_d     = irq_cause_s;
                    epc_d       = bus.commit_pc_i;
                    tgt_d       = irq_target_s;
                    busy_d      = 1'b1;
                    flush_d     = 1'b1;
                    mepc_we_d   = 1'b1;
                    mepc_d      = bus.commit_pc_i & ~{{(XLEN-1){1'b0}}, 1'b1};
                    mcause_we_d = 1'b1;
                    mcause_d    = irq_cause_s;
                    mtrap_d     = 1'b1;
                end else if (bus.mret_i) begin
                    state_d     = ST_RET;
                    tgt_d       = bus.mepc_i;
                    mpp_d       = bus.mstatus_mpp_i;
                    busy_d      = 1'b1;
                    flush_d     = 1'b1;
                    mret_d      = 1'b1;
                    pc_load_d   = 1'b1;
                    pc_target_d = bus.mepc_i;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_SAVE: begin
                state_d     = ST_JUMP;
                priv_d      = PRIV_MACHINE;
                busy_d      = 1'b1;
                pc_load_d   = 1'b1;
                pc_target_d = tgt_q;
            end
            ST_JUMP: begin
                state_d = ST_IDLE;
            end
            ST_RET: begin
                state_d = ST_IDLE;
                // Only USER and MACHINE exist; any MPP other than MACHINE returns to USER
                if (mpp_q == PRIV_MACHINE) begin
                    priv_d = PRIV_MACHINE;
                end else begin
                    priv_d = PRIV_USER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched trap context and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cause_q     <= {XLEN{1'b0}};
            epc_q       <= {XLEN{1'b0}};
            tgt_q       <= {XLEN{1'b0}};
            mpp_q       <= PRIV_USER;
            priv_q      <= PRIV_MACHINE;
            busy_q      <= 1'b0;
            flush_q     <= 1'b0;
            mepc_we_q   <= 1'b0;
            mepc_q      <= {XLEN{1'b0}};
            mcause_we_q <= 1'b0;
            mcause_q    <= {XLEN{1'b0}};
            mtrap_q     <= 1'b0;
            mret_q      <= 1'b0;
            pc_load_q   <= 1'b0;
            pc_target_q <= {XLEN{1'b0}};
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            tgt_q       <= tgt_d;
            mpp_q       <= mpp_d;
            priv_q      <= priv_d;
            busy_q      <= busy_d;
            flush_q     <= flush_d;
            mepc_we_q   <= mepc_we_d;
            mepc_q      <= mepc_d;
            mcause_we_q <= mcause_we_d;
            mcause_q    <= mcause_d;
            mtrap_q     <= mtrap_d;
            mret_q      <= mret_d;
            pc_load_q   <= pc_load_d;
            pc_target_q <= pc_target_d;
        end
    end

    assign bus.busy_o         = busy_q;
    assign bus.flush_o        = flush_q;
    assign bus.mepc_we_o      = mepc_we_q;
    assign bus.mepc_o         = mepc_q;
    assign bus.mcause_we_o    = mcause_we_q;
    assign bus.mcause_o       = mcause_q;
    assign bus.mstatus_trap_o = mtrap_q;
    assign bus.mstatus_mret_o = mret_q;
    assign bus.pc_load_o      = pc_load_q;
    assign bus.pc_target_o    = pc_target_q;
    assign bus.priv_o         = priv_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: exceptions, interrupts, MRET, priority and mid-sequence reset.
module tb_trap_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    trap_sequencer_if #(.XLEN(32), .CODE_WIDTH(5)) bus ();

    trap_sequencer #(.XLEN(32), .CODE_WIDTH(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] vec_exp;
`ifdef TRAP_VECTORED_MODE_EN
        vec_exp = 32'h0000_802C;
`else
        vec_exp = 32'h0000_8000;
`endif
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.exception_i      = 1'b0;
        bus.exception_code_i = 5'd0;
        bus.exception_pc_i   = 32'h0;
        bus.commit_valid_i   = 1'b0;
        bus.commit_pc_i      = 32'h0;
        bus.mret_i           = 1'b0;
        bus.mei_i            = 1'b0;
        bus.mti_i            = 1'b0;
        bus.msi_i            = 1'b0;
        bus.mie_i            = 32'h0;
        bus.mstatus_mie_i    = 1'b0;
        bus.mstatus_mpp_i    = 2'b00;
        bus.mtvec_i          = 32'h0000_8000;
        bus.mepc_i           = 32'h0;
        @(negedge clk);
        step();
        step();
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_flush", {31'd0, bus.flush_o}, 32'd0);
        chk("rst_pcload", {31'd0, bus.pc_load_o}, 32'd0);
        chk("rst_mcause", bus.mcause_o, 32'd0);
        chk("rst_priv", {30'd0, bus.priv_o}, 32'd3);
        rst = 1'b0;
        step();
        chk("idle_busy", {31'd0, bus.busy_o}, 32'd0);

        // Exception code 2 at 0x100
        bus.exception_i = 1'b1; bus.exception_code_i = 5'd2; bus.exception_pc_i = 32'h100;
        step();
        bus.exception_i = 1'b0;
        chk("exc_save_busy", {31'd0, bus.busy_o}, 32'd1);
        chk("exc_save_flush", {31'd0, bus.flush_o}, 32'd1);
        chk("exc_save_we", {29'd0, bus.mepc_we_o, bus.mcause_we_o, bus.mstatus_trap_o}, 32'd7);
        chk("exc_save_mepc", bus.mepc_o, 32'h100);
        chk("exc_save_mcause", bus.mcause_o, 32'h2);
        chk("exc_save_pcload", {31'd0, bus.pc_load_o}, 32'd0);
        step();
        chk("exc_jump_pcload", {31'd0, bus.pc_load_o}, 32'd1);
        chk("exc_jump_target", bus.pc_target_o, 32'h8000);
        chk("exc_jump_strobes", {29'd0, bus.flush_o, bus.mepc_we_o, bus.mstatus_trap_o}, 32'd0);
        chk("exc_jump_busy", {31'd0, bus.busy_o}, 32'd1);
        step();
        chk("exc_idle_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("exc_idle_pcload", {31'd0, bus.pc_load_o}, 32'd0);

        // Timer interrupt
        bus.mti_i = 1'b1; bus.mie_i = 32'h80; bus.mstatus_mie_i = 1'b1;
        bus.commit_valid_i = 1'b1; bus.commit_pc_i = 32'h204;
        step();
        bus.mti_i = 1'b0; bus.commit_valid_i = 1'b0;
        chk("mti_mcause", bus.mcause_o, 32'h8000_0007);
        chk("mti_mepc", bus.mepc_o, 32'h204);
        step();
        chk("mti_target", bus.pc_target_o, 32'h8000);
        step();

        // Exception beats MEI+MSI; pending IRQs re-evaluated afterwards
        bus.exception_i = 1'b1; bus.exception_code_i = 5'd11; bus.exception_pc_i = 32'h300;
        bus.mei_i = 1'b1; bus.msi_i = 1'b1; bus.mie_i = 32'h888;
        bus.commit_valid_i = 1'b1; bus.commit_pc_i = 32'h304;
        step();
        bus.exception_i = 1'b0;
        chk("prio_exc_mcause", bus.mcause_o, 32'hB);
        chk("prio_exc_mepc", bus.mepc_o, 32'h300);
        step();
        step();
        chk("prio_gap_busy", {31'd0, bus.busy_o}, 32'd0);
        step();
        bus.mei_i = 1'b0;
        chk("prio_mei_mcause", bus.mcause_o, 32'h8000_000B);
        chk("prio_mei_mepc", bus.mepc_o, 32'h304);
        step();
        step();
        step();
        bus.msi_i = 1'b0; bus.commit_valid_i = 1'b0;
        chk("prio_msi_mcause", bus.mcause_o, 32'h8000_0003);
        step();
        step();

        // Vectored-mode mtvec with MEI, then an exception at odd PC
        bus.mtvec_i = 32'h8001; bus.mei_i = 1'b1; bus.commit_valid_i = 1'b1;
        step();
        bus.mei_i = 1'b0; bus.commit_valid_i = 1'b0;
        chk("vec_mei_mcause", bus.mcause_o, 32'h8000_000B);
        step();
        chk("vec_mei_target", bus.pc_target_o, vec_exp);
        step();
        bus.exception_i = 1'b1; bus.exception_code_i = 5'd5; bus.exception_pc_i = 32'h101;
        step();
        bus.exception_i = 1'b0;
        chk("vec_exc_mepc_even", bus.mepc_o, 32'h100);
        chk("vec_exc_mcause", bus.mcause_o, 32'h5);
        step();
        chk("vec_exc_target", bus.pc_target_o, 32'h8000);
        step();
        bus.mtvec_i = 32'h8000;

        // Interrupt masked in MACHINE with MIE=0, and without commit_valid
        bus.mti_i = 1'b1; bus.mie_i = 32'h80; bus.mstatus_mie_i = 1'b0; bus.commit_valid_i = 1'b1;
        step();
        chk("mask_mie0_busy", {31'd0, bus.busy_o}, 32'd0);
        bus.mstatus_mie_i = 1'b1; bus.commit_valid_i = 1'b0;
        step();
        chk("mask_nocommit_busy", {31'd0, bus.busy_o}, 32'd0);
        bus.mti_i = 1'b0;

        // MRET to USER
        bus.mret_i = 1'b1; bus.mepc_i = 32'h340; bus.mstatus_mpp_i = 2'b00;
        step();
        bus.mret_i = 1'b0;
        chk("mret_strobes", {28'd0, bus.flush_o, bus.mstatus_mret_o, bus.pc_load_o, bus.busy_o}, 32'hF);
        chk("mret_target", bus.pc_target_o, 32'h340);
        chk("mret_no_trap", {31'd0, bus.mstatus_trap_o}, 32'd0);
        step();
        chk("mret_priv_user", {30'd0, bus.priv_o}, 32'd0);
        chk("mret_idle_busy", {31'd0, bus.busy_o}, 32'd0);

        // USER takes MTI even with MIE=0; interrupt beats a simultaneous MRET
        bus.mti_i = 1'b1; bus.mie_i = 32'h80; bus.mstatus_mie_i = 1'b0;
        bus.commit_valid_i = 1'b1; bus.commit_pc_i = 32'h400; bus.mret_i = 1'b1;
        step();
        bus.mti_i = 1'b0; bus.commit_valid_i = 1'b0; bus.mret_i = 1'b0;
        chk("user_mti_mcause", bus.mcause_o, 32'h8000_0007);
        chk("user_mti_mepc", bus.mepc_o, 32'h400);
        chk("user_mti_no_mret", {31'd0, bus.mstatus_mret_o}, 32'd0);
        chk("user_save_priv", {30'd0, bus.priv_o}, 32'd0);
        step();
        chk("user_jump_priv", {30'd0, bus.priv_o}, 32'd3);
        step();

        // Exception beats a simultaneous MRET
        bus.exception_i = 1'b1; bus.exception_code_i = 5'd3; bus.exception_pc_i = 32'h500;
        bus.mret_i = 1'b1;
        step();
        bus.exception_i = 1'b0; bus.mret_i = 1'b0;
        chk("exc_mret_trap", {30'd0, bus.mstatus_trap_o, bus.mstatus_mret_o}, 32'd2);
        chk("exc_mret_mcause", bus.mcause_o, 32'h3);
        step();
        step();

        // MPP=SUPERVISOR returns to USER, MPP=MACHINE to MACHINE
        bus.mret_i = 1'b1; bus.mepc_i = 32'h600; bus.mstatus_mpp_i = 2'b01;
        step();
        bus.mret_i = 1'b0;
        step();
        chk("mpp01_priv", {30'd0, bus.priv_o}, 32'd0);
        bus.mret_i = 1'b1; bus.mstatus_mpp_i = 2'b11;
        step();
        bus.mret_i = 1'b0;
        step();
        chk("mpp11_priv", {30'd0, bus.priv_o}, 32'd3);

        // Reset during SAVE
        bus.exception_i = 1'b1; bus.exception_code_i = 5'd1; bus.exception_pc_i = 32'h700;
        step();
        bus.exception_i = 1'b0;
        chk("rstsave_we", {31'd0, bus.mepc_we_o}, 32'd1);
        rst = 1'b1;
        step();
        chk("rstsave_strobes", {26'd0, bus.flush_o, bus.mepc_we_o, bus.mcause_we_o,
                                bus.mstatus_trap_o, bus.mstatus_mret_o, bus.pc_load_o}, 32'd0);
        chk("rstsave_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rstsave_priv", {30'd0, bus.priv_o}, 32'd3);
        rst = 1'b0;
        step();
        chk("rstsave_no_jump", {30'd0, bus.pc_load_o, bus.busy_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
